// File: rtl/interrupt_controller.sv
// Fixed-priority, non-nested interrupt controller.
// Arbitrates enabled level IRQs (bit 0 highest priority), raises one CPU
// interrupt with a vector, and returns one-cycle IACK/IEND pulses to the
// serviced source.
module interrupt_controller #(
  parameter int NUM_SRC = 8,
  parameter int VEC_W   = 3
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_SRC-1:0] SRC_IRQ,
  input  logic [NUM_SRC-1:0] IRQ_ENABLE,
  input  logic               GLOBAL_EN,
  output logic [NUM_SRC-1:0] SRC_IACK,
  output logic [NUM_SRC-1:0] SRC_IEND,
  output logic               CPU_INT,
  input  logic               CPU_ACK,
  output logic [VEC_W-1:0]   CPU_VECTOR,
  input  logic               CPU_IEND,
  output logic               IN_SERVICE
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_SERVICE,
    S_END
  } state_t;

  state_t               state, state_n;
  logic [NUM_SRC-1:0]   pending;
  logic [NUM_SRC-1:0]   cur_onehot;
  logic [VEC_W-1:0]     winner;
  logic                 found;

  logic                 cpu_int_n;
  logic [VEC_W-1:0]     cpu_vector_n;
  logic [NUM_SRC-1:0]   src_iack_n;
  logic [NUM_SRC-1:0]   src_iend_n;
  logic                 in_service_n;

  assign pending    = SRC_IRQ & IRQ_ENABLE;
  // CPU_VECTOR doubles as the latched current source once committed in IDLE.
  assign cur_onehot = NUM_SRC'(1'b1) << CPU_VECTOR;

  // Priority encoder: lowest set index of the pending vector wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (pending[i] && !found) begin
        winner = VEC_W'(i);
        found  = 1'b1;
      end
    end
  end

  // Next-state and next-output logic; pulses default low every cycle.
  always_comb begin
    state_n      = state;
    cpu_int_n    = CPU_INT;
    cpu_vector_n = CPU_VECTOR;
    src_iack_n   = '0;
    src_iend_n   = '0;
    in_service_n = IN_SERVICE;
    unique case (state)
      S_IDLE: begin
        if (GLOBAL_EN && found) begin
          cpu_vector_n = winner;
          cpu_int_n    = 1'b1;
          state_n      = S_REQ;
        end
      end
      S_REQ: begin
        if (CPU_ACK) begin
          cpu_int_n    = 1'b0;
          src_iack_n   = cur_onehot;
          in_service_n = 1'b1;
          state_n      = S_SERVICE;
        end
      end
      S_SERVICE: begin
        if (CPU_IEND) begin
          src_iend_n = cur_onehot;
          state_n    = S_END;
        end
      end
      S_END: begin
        in_service_n = 1'b0;
        state_n      = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts service without any pulse.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= S_IDLE;
      CPU_INT    <= 1'b0;
      CPU_VECTOR <= '0;
      SRC_IACK   <= '0;
      SRC_IEND   <= '0;
      IN_SERVICE <= 1'b0;
    end else begin
      state      <= state_n;
      CPU_INT    <= cpu_int_n;
      CPU_VECTOR <= cpu_vector_n;
      SRC_IACK   <= src_iack_n;
      SRC_IEND   <= src_iend_n;
      IN_SERVICE <= in_service_n;
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench for interrupt_controller: each transaction is turned into
// a timeline of expected output snapshots; a monitor compares every cycle in
// which the DUT outputs change (or were expected to change).
module tb_interrupt_controller;

  localparam int N  = 8;
  localparam int VW = 3;

  logic          clk = 1'b0;
  logic          RESET;
  logic [N-1:0]  SRC_IRQ, IRQ_ENABLE;
  logic          GLOBAL_EN;
  logic [N-1:0]  SRC_IACK, SRC_IEND;
  logic          CPU_INT;
  logic          CPU_ACK;
  logic [VW-1:0] CPU_VECTOR;
  logic          CPU_IEND;
  logic          IN_SERVICE;

  interrupt_controller #(.NUM_SRC(N), .VEC_W(VW)) dut (
    .CLK(clk), .RESET(RESET), .SRC_IRQ(SRC_IRQ), .IRQ_ENABLE(IRQ_ENABLE),
    .GLOBAL_EN(GLOBAL_EN), .SRC_IACK(SRC_IACK), .SRC_IEND(SRC_IEND),
    .CPU_INT(CPU_INT), .CPU_ACK(CPU_ACK), .CPU_VECTOR(CPU_VECTOR),
    .CPU_IEND(CPU_IEND), .IN_SERVICE(IN_SERVICE)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  // Cycle index: value c means "after rising edge c".
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic          cint;
    logic [VW-1:0] vec;
    logic [N-1:0]  iack;
    logic [N-1:0]  iend;
    logic          svc;
  } snap_t;

  typedef struct {
    int    c;
    snap_t s;
  } exp_t;

  exp_t  q[$];
  snap_t model_last = '0;
  snap_t mon_last   = '0;
  bit    mon_on     = 1'b0;
  int    checks     = 0;
  int    failures   = 0;

  // Record an expected snapshot only when it differs from the previous one.
  function automatic void expect_at(int c, snap_t s);
    if (s != model_last) begin
      q.push_back('{c: c, s: s});
      model_last = s;
    end
  endfunction

  // Monitor: compare on every observed output change or expected change.
  always @(negedge clk) begin : mon
    snap_t obs;
    if (mon_on) begin
      obs = '{cint: CPU_INT, vec: CPU_VECTOR, iack: SRC_IACK, iend: SRC_IEND, svc: IN_SERVICE};
      while (q.size() > 0 && q[0].c < cyc) begin
        checks++; failures++;
        $display("FAIL missed_change cycle=%0d actual=none required=%h", q[0].c, q[0].s);
        void'(q.pop_front());
      end
      if (obs !== mon_last) begin
        checks++;
        if (q.size() > 0 && q[0].c == cyc) begin
          if (obs !== q[0].s) begin
            failures++;
            $display("FAIL output_change cycle=%0d actual=%h required=%h", cyc, obs, q[0].s);
          end
          void'(q.pop_front());
        end else begin
          failures++;
          $display("FAIL unexpected_change cycle=%0d actual=%h required=%h", cyc, obs, mon_last);
        end
      end else if (q.size() > 0 && q[0].c == cyc) begin
        checks++; failures++;
        $display("FAIL no_change cycle=%0d actual=%h required=%h", cyc, obs, q[0].s);
        void'(q.pop_front());
      end
      mon_last = obs;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One transaction starting at the current cycle with the DUT idle.
  // ackdly: REQ cycles before CPU_ACK; svcdly: SERVICE cycles before CPU_IEND;
  // rstdly >= 0 aborts with RESET that many cycles into SERVICE.
  task automatic txn(input logic [N-1:0] irq, input logic [N-1:0] en, input logic ge,
                     input logic [N-1:0] irq_mid, input int ackdly, input int svcdly,
                     input int rstdly);
    logic [N-1:0] pend, oh;
    int w, d0, t1, a, k, r, last;
    snap_t s;
    pend = irq & en;
    d0 = cyc;
    SRC_IRQ = irq; IRQ_ENABLE = en; GLOBAL_EN = ge;
    CPU_ACK = rbit(); CPU_IEND = rbit();
    if (!ge || pend == '0) begin
      for (int i = 0; i < ackdly; i++) begin
        step();
        CPU_ACK = rbit(); CPU_IEND = rbit();
      end
      step();
      return;
    end
    oh = pend & (~pend + 1'b1);
    w  = $clog2(oh);
    t1 = d0 + 1;
    a  = t1 + ackdly;
    k  = a + 1 + svcdly;
    r  = (rstdly >= 0) ? a + 1 + rstdly : -1;
    last = (r >= 0) ? r : k + 1;
    for (int c = t1; c <= ((r >= 0) ? r : k + 2); c++) begin
      s.cint = (c <= a);
      s.vec  = VW'(w);
      s.iack = (c == a + 1) ? oh : '0;
      s.iend = (r < 0 && c == k + 1) ? oh : '0;
      s.svc  = (c >= a + 1) && (r >= 0 || c <= k + 1);
      expect_at(c, s);
    end
    if (r >= 0) expect_at(r + 1, '0);
    step();
    for (int c = t1; c <= last; c++) begin
      if (c == t1) SRC_IRQ = irq_mid;
      else begin
        GLOBAL_EN = rbit();
        if ($urandom_range(0, 3) == 0) IRQ_ENABLE = N'($urandom);
      end
      RESET = (c == r);
      if (c <= a) begin
        CPU_ACK = (c == a); CPU_IEND = rbit();
      end else if (c == r) begin
        CPU_ACK = rbit(); CPU_IEND = rbit();
      end else if (r < 0 && c == k) begin
        CPU_ACK = rbit(); CPU_IEND = 1'b1;
      end else if (r < 0 && c == k + 1) begin
        CPU_ACK = rbit(); CPU_IEND = rbit();
      end else begin
        CPU_ACK = rbit(); CPU_IEND = 1'b0;
      end
      step();
    end
    RESET = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout cycle=%0d actual=running required=finished", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] irq, en, mid;
    logic         ge;
    RESET = 1'b1; SRC_IRQ = '0; IRQ_ENABLE = '0; GLOBAL_EN = 1'b0;
    CPU_ACK = 1'b0; CPU_IEND = 1'b0;
    step();
    step();
    checks++;
    if ({CPU_INT, CPU_VECTOR, SRC_IACK, SRC_IEND, IN_SERVICE} !== '0) begin
      failures++;
      $display("FAIL reset_state actual=%h required=0",
               {CPU_INT, CPU_VECTOR, SRC_IACK, SRC_IEND, IN_SERVICE});
    end
    RESET = 1'b0;
    mon_last = '0;
    mon_on = 1'b1;

    txn(8'h01, 8'hFF, 1'b1, 8'h01, 1, 1, -1);
    txn(8'h28, 8'hFF, 1'b1, 8'h28, 0, 0, -1);
    txn(8'h20, 8'hFF, 1'b1, 8'h20, 0, 0, -1);
    txn(8'h04, 8'hFF, 1'b1, 8'h05, 2, 1, -1);
    txn(8'h01, 8'hFE, 1'b1, 8'h01, 5, 0, -1);
    txn(8'h02, 8'hFF, 1'b0, 8'h02, 3, 0, -1);
    txn(8'h02, 8'hFF, 1'b1, 8'h02, 0, 2, -1);
    txn(8'h10, 8'hFF, 1'b1, 8'h10, 1, 0, 1);
    txn(8'h10, 8'hFF, 1'b1, 8'h10, 0, 0, -1);
    txn(8'h80, 8'hFF, 1'b1, 8'h00, 3, 3, 0);
    txn(8'h80, 8'hFF, 1'b1, 8'h00, 0, 0, -1);

    irq = 8'h80;
    for (int n = 0; n < 300; n++) begin
      if (rbit()) irq = irq & ~(irq & (~irq + 1'b1));
      if ($urandom_range(0, 3) == 0 || irq == '0) irq = N'($urandom);
      en  = ($urandom_range(0, 3) == 0) ? N'($urandom) : 8'hFF;
      ge  = ($urandom_range(0, 4) != 0);
      mid = rbit() ? N'($urandom) : irq;
      txn(irq, en, ge, mid, $urandom_range(0, 3), $urandom_range(0, 3),
          ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2)) : -1);
    end

    SRC_IRQ = '0; IRQ_ENABLE = '0; GLOBAL_EN = 1'b0; CPU_ACK = 1'b0; CPU_IEND = 1'b0;
    repeat (4) step();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL leftover_expectations actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Sits directly downstream of system_timer and the other interrupt-generating peripherals; consumes their level IRQ lines.
- Returns per-source IACK and IEND pulses, which is the handshake system_timer expects on INTC_IACK and INTC_IEND.
- Arbitrates pending sources by fixed priority, raises a single interrupt to the CPU with a vector, and tracks one in-service interrupt at a time (non-nested).

Parameters:
NUM_SRC, 8, number of interrupt sources; bit 0 is highest priority; system timer is wired to bit 0
VEC_W, 3, width of the vector output; must satisfy 2^VEC_W >= NUM_SRC

Ports:
CLK  in  1  system clock; all logic on rising edge
RESET  in  1  synchronous, active-high reset
SRC_IRQ  in  NUM_SRC  level interrupt requests from sources (bit i = source i)
IRQ_ENABLE  in  NUM_SRC  per-source enable mask; 0 = source ignored for arbitration
GLOBAL_EN  in  1  master interrupt enable; 0 = no new arbitration
SRC_IACK  out  NUM_SRC  one-cycle acknowledge pulse to the serviced source (one-hot)
SRC_IEND  out  NUM_SRC  one-cycle end-of-service pulse to the serviced source (one-hot)
CPU_INT  out  1  interrupt request to CPU
CPU_ACK  in  1  CPU accepts the interrupt; sampled only while CPU_INT=1
CPU_VECTOR  out  VEC_W  index of the current source
CPU_IEND  in  1  CPU signals ISR completion
IN_SERVICE  out  1  high from CPU_ACK acceptance until the END state is left

Behaviour:
Reset values:
- All outputs are registered.
- On RESET=1 at a clock edge: state=IDLE, CPU_INT=0, CPU_VECTOR=0, SRC_IACK=0, SRC_IEND=0, IN_SERVICE=0.
- Reset mid-operation aborts any service silently; no IACK/IEND pulse is emitted.

State machine: IDLE, REQ, SERVICE, END.
- IDLE:
  - pending = SRC_IRQ & IRQ_ENABLE.
  - If GLOBAL_EN=1 and pending!=0: latch cur = lowest set index of pending, CPU_VECTOR<=cur, CPU_INT<=1, go REQ.
  - Latency: IRQ high at edge n results in CPU_INT high after edge n.
- REQ:
  - CPU_INT held at 1 and CPU_VECTOR held.
  - The choice is committed: later SRC_IRQ, IRQ_ENABLE or GLOBAL_EN changes, including a higher-priority arrival or withdrawal of cur, do not change cur.
  - On CPU_ACK=1: CPU_INT<=0, SRC_IACK[cur]<=1 for exactly one cycle, IN_SERVICE<=1, go SERVICE.
  - CPU_IEND is ignored in REQ, including when it arrives in the same cycle as CPU_ACK.
- SERVICE:
  - Wait for CPU_IEND=1, then SRC_IEND[cur]<=1 for exactly one cycle and go END.
  - CPU_ACK is ignored.
- END:
  - One mandatory gap cycle so the source can drop its IRQ after IEND.
  - IN_SERVICE<=0, go IDLE.
  - No arbitration in this cycle.

Timing:
- CPU_ACK at edge m gives the IACK pulse in cycle m+1.
- CPU_IEND at edge k gives the IEND pulse in cycle k+1, END in cycle k+1 and IDLE in cycle k+2.
- Earliest re-raise of CPU_INT is after edge k+2.

Boundary conditions:
- CPU_ACK or CPU_IEND arriving in IDLE or END is ignored; there is no stored or pending state.
- Several simultaneous pending sources: lowest index wins; the others stay pending at their sources and win on later passes.
- A source still asserting IRQ after END is re-serviced as a new interrupt.
- GLOBAL_EN=0 blocks only the IDLE->REQ transition. An interrupt already in REQ or SERVICE completes normally.
- At most one SRC_IACK or SRC_IEND bit is ever high, never both in the same cycle.
- CPU_VECTOR keeps its last value in IDLE.

Test Plan:
- Reset, then SRC_IRQ=0x01, IRQ_ENABLE=0xFF, GLOBAL_EN=1: CPU_INT=1 one cycle later with CPU_VECTOR=0. CPU_ACK pulse gives SRC_IACK=0x01 for one cycle. CPU_IEND pulse gives SRC_IEND=0x01 for one cycle. IN_SERVICE returns to 0 two cycles after CPU_IEND.
- SRC_IRQ=0x28 simultaneous: CPU_VECTOR=3, then IACK/IEND on bit 3. After END, with bit 5 still high, CPU_INT re-raises with CPU_VECTOR=5 three cycles after the first CPU_IEND.
- Priority commit: SRC_IRQ=0x04 enters REQ, then SRC_IRQ=0x05 before CPU_ACK: CPU_VECTOR stays 2 and SRC_IACK=0x04.
- Masking: IRQ_ENABLE=0xFE with SRC_IRQ=0x01 gives CPU_INT=0 indefinitely. GLOBAL_EN=0 with SRC_IRQ=0x02 gives CPU_INT=0; setting GLOBAL_EN=1 gives CPU_INT=1 next cycle.
- Spurious/simultaneous handshakes: CPU_IEND in IDLE gives no pulse. CPU_ACK and CPU_IEND together in REQ give IACK only, with state SERVICE. A second CPU_ACK in SERVICE gives no pulse.
- Reset mid-SERVICE (after IACK, before CPU_IEND): next cycle all outputs are 0 and no SRC_IEND is produced. Re-arbitration starts normally after RESET drops.
